// File: rtl/lvds_link_trainer.sv
// LVDS link trainer: waits for PLL lock, bit-slips the receiver until the training
// pattern is seen MATCH_CNT times in a row, then passes user payload to the transmitter.
module lvds_link_trainer #(
  parameter logic [7:0] TRAIN_PAT  = 8'hA5,
  parameter int         LOCK_WAIT  = 64,
  parameter int         SETTLE_CYC = 4,
  parameter int         MATCH_CNT  = 16,
  parameter int         MAX_SLIP   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       retrain,
  input  logic [7:0] rx_data,
  input  logic [7:0] user_tx,
  output logic [7:0] tx_data,
  output logic       rx_data_align,
  output logic       link_up,
  output logic       train_fail,
  output logic [3:0] slip_count
);

  localparam int WMAX = (LOCK_WAIT > SETTLE_CYC) ? LOCK_WAIT : SETTLE_CYC;
  localparam int WW   = $clog2(WMAX + 1);
  localparam int MW   = $clog2(MATCH_CNT + 1);

  localparam logic [WW-1:0] LOCK_LAST   = WW'(LOCK_WAIT - 1);
  localparam logic [WW-1:0] SETTLE_LAST = WW'(SETTLE_CYC - 1);
  localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_CNT - 1);
  localparam logic [3:0]    SLIP_MAX    = 4'(MAX_SLIP);

  typedef enum logic [2:0] {
    IDLE, WAIT_LOCK, CHECK, SLIP, SETTLE, LINK_UP, FAIL
  } state_t;

  state_t        state, state_next;
  logic [WW-1:0] wait_cnt, wait_next;
  logic [MW-1:0] match_cnt, match_next;
  logic [3:0]    slip_next;
  logic          fail_next;

  // One shared wait counter serves WAIT_LOCK, SETTLE and FAIL; it saturates at all ones.
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    match_next = match_cnt;
    slip_next  = slip_count;
    fail_next  = train_fail;
    if (state != IDLE && !pll_locked) begin
      state_next = IDLE;
      wait_next  = '0;
      match_next = '0;
      slip_next  = '0;
    end else if (state != IDLE && retrain) begin
      state_next = WAIT_LOCK;
      wait_next  = '0;
      match_next = '0;
      slip_next  = '0;
      fail_next  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pll_locked) begin
            state_next = WAIT_LOCK;
            wait_next  = '0;
          end
        end
        WAIT_LOCK, FAIL: begin
          if (wait_cnt == LOCK_LAST) begin
            state_next = CHECK;
            wait_next  = '0;
            match_next = '0;
            if (state == WAIT_LOCK) slip_next = '0;
          end else if (wait_cnt != '1) begin
            wait_next = wait_cnt + WW'(1);
          end
        end
        CHECK: begin
          if (rx_data == TRAIN_PAT) begin
            if (match_cnt != '1) match_next = match_cnt + MW'(1);
            if (match_cnt == MATCH_LAST) begin
              state_next = LINK_UP;
              fail_next  = 1'b0;
            end
          end else begin
            match_next = '0;
            if (slip_count < SLIP_MAX) begin
              state_next = SLIP;
              slip_next  = slip_count + 4'd1;
            end else begin
              state_next = FAIL;
              fail_next  = 1'b1;
              slip_next  = '0;
              wait_next  = '0;
            end
          end
        end
        SLIP: begin
          state_next = SETTLE;
          wait_next  = '0;
        end
        SETTLE: begin
          if (wait_cnt == SETTLE_LAST) begin
            state_next = CHECK;
            wait_next  = '0;
            match_next = '0;
          end else if (wait_cnt != '1) begin
            wait_next = wait_cnt + WW'(1);
          end
        end
        LINK_UP: ;
        default: begin
          state_next = IDLE;
          wait_next  = '0;
          match_next = '0;
          slip_next  = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      match_cnt     <= '0;
      slip_count    <= '0;
      train_fail    <= 1'b0;
      link_up       <= 1'b0;
      rx_data_align <= 1'b0;
      tx_data       <= TRAIN_PAT;
    end else begin
      state         <= state_next;
      wait_cnt      <= wait_next;
      match_cnt     <= match_next;
      slip_count    <= slip_next;
      train_fail    <= fail_next;
      link_up       <= (state_next == LINK_UP);
      rx_data_align <= (state_next == SLIP);
      tx_data       <= (state_next == LINK_UP) ? user_tx : TRAIN_PAT;
    end
  end

endmodule

// File: tb/tb_lvds_link_trainer.sv
// Directed bench for lvds_link_trainer: lock-up, bit-slip alignment, failed rounds,
// lock loss / retrain priority and asynchronous reset.
module tb_lvds_link_trainer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       retrain = 1'b0;
  logic [7:0] rx_drive = 8'h00;
  logic [7:0] user_tx = 8'h00;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic       rx_data_align;
  logic       link_up;
  logic       train_fail;
  logic [3:0] slip_count;

  int total = 0;
  int bad = 0;

  // Receiver model: rotated training word, rotation reduced by one per slip pulse.
  logic        model_en = 1'b0;
  int          rot = 0;
  logic [15:0] rot_dbl;
  assign rot_dbl = {8'hA5, 8'hA5} << rot;
  assign rx_data = model_en ? rot_dbl[15:8] : rx_drive;

  always @(posedge clk) begin
    if (model_en && rx_data_align && rot > 0) rot <= rot - 1;
  end

  lvds_link_trainer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .retrain      (retrain),
    .rx_data      (rx_data),
    .user_tx      (user_tx),
    .tx_data      (tx_data),
    .rx_data_align(rx_data_align),
    .link_up      (link_up),
    .train_fail   (train_fail),
    .slip_count   (slip_count)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled just after each rising edge.
  int   cyc = 0;
  int   last_cyc = 0;
  int   pulse_cnt = 0;
  int   gap_bad = 0;
  int   dbl_cnt = 0;
  int   slip_peak = 0;
  logic prev_align = 1'b0;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rx_data_align) begin
      if (prev_align) dbl_cnt++;
      if (pulse_cnt > 0 && (cyc - last_cyc) != 6) gap_bad++;
      last_cyc = cyc;
      pulse_cnt++;
    end
    if (int'(slip_count) > slip_peak) slip_peak = int'(slip_count);
    prev_align = rx_data_align;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int n;

  initial begin
    // Reset values while rst_n is low
    #12;
    chk("rst_tx", 32'(tx_data), 32'hA5);
    chk("rst_align", 32'(rx_data_align), 0);
    chk("rst_link", 32'(link_up), 0);
    chk("rst_fail", 32'(train_fail), 0);
    chk("rst_slip", 32'(slip_count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean lock: 1 + 64 + 16 edges to link up
    step(1);
    pll_locked = 1'b1;
    rx_drive = 8'hA5;
    pulse_cnt = 0;
    step(80);
    chk("a_link_early", 32'(link_up), 0);
    step(1);
    chk("a_link_up", 32'(link_up), 1);
    chk("a_slip", 32'(slip_count), 0);
    chk("a_pulses", 32'(pulse_cnt), 0);

    // Payload pass-through and lock loss
    user_tx = 8'h3C;
    step(1);
    chk("tx_user", 32'(tx_data), 32'h3C);
    pll_locked = 1'b0;
    step(1);
    chk("loss_link", 32'(link_up), 0);
    chk("loss_tx", 32'(tx_data), 32'hA5);

    // Bit-slip alignment from a 3-bit rotation
    rot = 3;
    model_en = 1'b1;
    pulse_cnt = 0;
    gap_bad = 0;
    pll_locked = 1'b1;
    n = 0;
    while (!link_up && n < 400) begin step(1); n++; end
    chk("b_link_up", 32'(link_up), 1);
    chk("b_pulses", 32'(pulse_cnt), 3);
    chk("b_gap", 32'(gap_bad), 0);
    chk("b_slip", 32'(slip_count), 3);
    model_en = 1'b0;
    rx_drive = 8'hA5;

    // Lock loss wins over retrain: back to IDLE, so 81 edges to relock
    retrain = 1'b1;
    pll_locked = 1'b0;
    step(1);
    retrain = 1'b0;
    chk("c_link_drop", 32'(link_up), 0);
    pll_locked = 1'b1;
    step(80);
    chk("c_idle_early", 32'(link_up), 0);
    step(1);
    chk("c_idle_relock", 32'(link_up), 1);

    // Retrain alone: WAIT_LOCK, so 80 edges to relock
    retrain = 1'b1;
    step(1);
    retrain = 1'b0;
    chk("d_link_drop", 32'(link_up), 0);
    step(79);
    chk("d_wl_early", 32'(link_up), 0);
    step(1);
    chk("d_wl_relock", 32'(link_up), 1);

    // Exhausted round with all-zero data
    rx_drive = 8'h00;
    retrain = 1'b1;
    step(1);
    retrain = 1'b0;
    pulse_cnt = 0;
    slip_peak = 0;
    n = 0;
    while (!train_fail && n < 400) begin step(1); n++; end
    chk("e_fail_set", 32'(train_fail), 1);
    chk("e_pulses", 32'(pulse_cnt), 8);
    chk("e_slip_clr", 32'(slip_count), 0);
    chk("e_slip_peak", 32'(slip_peak), 8);
    rx_drive = 8'hA5;
    pulse_cnt = 0;
    step(79);
    chk("e_link_early", 32'(link_up), 0);
    step(1);
    chk("e_link_up", 32'(link_up), 1);
    chk("e_fail_clr", 32'(train_fail), 0);
    chk("e_no_pulse", 32'(pulse_cnt), 0);

    // Asynchronous reset in the middle of a SLIP cycle
    rx_drive = 8'h00;
    retrain = 1'b1;
    step(1);
    retrain = 1'b0;
    n = 0;
    while (!train_fail && n < 400) begin step(1); n++; end
    n = 0;
    while (!rx_data_align && n < 200) begin step(1); n++; end
    chk("f_in_slip", 32'(rx_data_align), 1);
    chk("f_fail_before", 32'(train_fail), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("f_align", 32'(rx_data_align), 0);
    chk("f_link", 32'(link_up), 0);
    chk("f_fail", 32'(train_fail), 0);
    chk("f_slip", 32'(slip_count), 0);
    chk("f_tx", 32'(tx_data), 32'hA5);
    @(negedge clk);
    rst_n = 1'b1;

    // Retrain clears a sticky failure
    n = 0;
    while (!train_fail && n < 400) begin step(1); n++; end
    chk("g_fail_set", 32'(train_fail), 1);
    retrain = 1'b1;
    step(1);
    retrain = 1'b0;
    chk("g_fail_clr", 32'(train_fail), 0);
    chk("g_slip_clr", 32'(slip_count), 0);

    chk("no_double_pulse", 32'(dbl_cnt), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
